// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCK_B = 1'b1
  } arb_state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  localparam int WORD_OFFSET_BITS = 2;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way grant picker with one-hot {gnt_b, gnt_a} output.
// Zero latency; a locked B suppresses A regardless of A's valid.
module dmem_rr_pick
  import dmem_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic a_valid_i,
  input  logic b_valid_i,
  input  logic last_gnt_i,
  input  logic locked_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (locked_i) begin
      gnt_b_o = b_valid_i;
    end else if (a_valid_i && b_valid_i) begin
      // On conflict the port that did not win last time goes first.
      if ((FIXED_PRIO != 0) || (last_gnt_i == GNT_B)) begin
        gnt_a_o = 1'b1;
      end else begin
        gnt_b_o = 1'b1;
      end
    end else begin
      gnt_a_o = a_valid_i;
      gnt_b_o = b_valid_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between ports A and B; one-cycle registered response, B may lock.
// Define DMEM_ARB_ALIGN_CHK_EN to flag and suppress misaligned accesses via a_err_o/b_err_o.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_resp_valid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_resp_valid_o,
  output logic [DATA_W-1:0] b_rdata_o,
`ifdef DMEM_ARB_ALIGN_CHK_EN
  output logic              a_err_o,
  output logic              b_err_o,
`endif
  input  logic              b_lock_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_write_enable_o,
  input  logic [DATA_W-1:0] mem_read_data_i
);

  localparam int WORD_W = ADDR_W - WORD_OFFSET_BITS;

  arb_state_e        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              a_resp_q, a_resp_d, b_resp_q, b_resp_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic              gnt_a, gnt_b, accept, locked;
  logic              a_bad, b_bad, sel_we, sel_bad;
  logic [WORD_W-1:0] sel_word;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic a_err_q, a_err_d, b_err_q, b_err_d;
  assign a_bad = |a_addr_i[WORD_OFFSET_BITS-1:0];
  assign b_bad = |b_addr_i[WORD_OFFSET_BITS-1:0];
`else
  logic unused_byte_offset;
  assign unused_byte_offset = ^{a_addr_i[WORD_OFFSET_BITS-1:0], b_addr_i[WORD_OFFSET_BITS-1:0]};
  assign a_bad = 1'b0;
  assign b_bad = 1'b0;
`endif

  // The lock only binds while b_lock is still high; its falling cycle arbitrates normally.
  assign locked = (state_q == LOCK_B) && b_lock_i;

  dmem_rr_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .a_valid_i  (a_valid_i),
    .b_valid_i  (b_valid_i),
    .last_gnt_i (last_gnt_q),
    .locked_i   (locked),
    .gnt_a_o    (gnt_a),
    .gnt_b_o    (gnt_b)
  );

  assign accept    = gnt_a | gnt_b;
  assign a_ready_o = gnt_a;
  assign b_ready_o = gnt_b;

  always_comb begin
    sel_word  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_bad   = 1'b0;
    if (gnt_a) begin
      sel_word  = a_addr_i[ADDR_W-1:WORD_OFFSET_BITS];
      sel_wdata = a_wdata_i;
      sel_we    = a_we_i;
      sel_bad   = a_bad;
    end else if (gnt_b) begin
      sel_word  = b_addr_i[ADDR_W-1:WORD_OFFSET_BITS];
      sel_wdata = b_wdata_i;
      sel_we    = b_we_i;
      sel_bad   = b_bad;
    end
  end

  assign mem_addr_o         = {sel_word, {WORD_OFFSET_BITS{1'b0}}};
  assign mem_write_data_o   = sel_wdata;
  assign mem_write_enable_o = sel_we & accept & ~reset_i & ~sel_bad;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    if (accept) last_gnt_d = gnt_b ? GNT_B : GNT_A;
    unique case (state_q)
      ARB:     if (gnt_b && b_lock_i) state_d = LOCK_B;
      LOCK_B:  if (!b_lock_i) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Writes and rejected accesses answer with zero data; reads capture memory data.
  always_comb begin
    a_resp_d  = gnt_a;
    b_resp_d  = gnt_b;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (gnt_a) a_rdata_d = (a_we_i || a_bad) ? '0 : mem_read_data_i;
    if (gnt_b) b_rdata_d = (b_we_i || b_bad) ? '0 : mem_read_data_i;
  end

`ifdef DMEM_ARB_ALIGN_CHK_EN
  always_comb begin
    a_err_d = a_err_q;
    b_err_d = b_err_q;
    if (gnt_a) a_err_d = a_bad;
    if (gnt_b) b_err_d = b_bad;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
    end else begin
      a_err_q <= a_err_d;
      b_err_q <= b_err_d;
    end
  end

  assign a_err_o = a_err_q;
  assign b_err_o = b_err_q;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ARB;
      last_gnt_q <= GNT_B;
      a_resp_q   <= 1'b0;
      b_resp_q   <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      a_resp_q   <= a_resp_d;
      b_resp_q   <= b_resp_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_resp_valid_o = a_resp_q;
  assign b_resp_valid_o = b_resp_q;
  assign a_rdata_o      = a_rdata_q;
  assign b_rdata_o      = b_rdata_q;

endmodule
